// File: rtl/unary_stream_tx.sv
// Serialises an operand pair into two thermometer-coded frames (A/B) of FRAME_LEN bits.
// Optional post-frame drain window (read_or_write=1) is enabled by defining UNARY_TX_DRAIN_EN.
module unary_stream_tx #(
  parameter int FRAME_LEN = 15,
  parameter int VAL_W     = 5,
  parameter int DRAIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [VAL_W-1:0] val_a,
  input  logic [VAL_W-1:0] val_b,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  output logic             frame_done,
  output logic             sat
);

  // state  | meaning
  // IDLE   | waiting for an operand pair, load_ready=1
  // STREAM | emitting frame bit idx_q on A/B with en=1
  // DRAIN  | downstream writes its result, read_or_write=1 (UNARY_TX_DRAIN_EN only)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
`ifdef UNARY_TX_DRAIN_EN
    , DRAIN = 2'd2
`endif
  } state_t;

  localparam logic [VAL_W-1:0] FRAME_MAX = VAL_W'(FRAME_LEN);
  localparam logic [VAL_W-1:0] LAST_IDX  = VAL_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] a_q, a_d;
  logic [VAL_W-1:0] b_q, b_d;
  logic             sat_d;
  logic             en_d, a_bit_d, b_bit_d, frame_done_d;

`ifdef UNARY_TX_DRAIN_EN
  localparam int DRAIN_W = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               rw_d;
`else
  logic unused_drain_len;
  assign unused_drain_len = ^DRAIN_LEN;
  assign read_or_write    = 1'b0;
`endif

  assign load_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat;
`ifdef UNARY_TX_DRAIN_EN
    drain_cnt_d = drain_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          a_d     = (val_a > FRAME_MAX) ? FRAME_MAX : val_a;
          b_d     = (val_b > FRAME_MAX) ? FRAME_MAX : val_b;
          sat_d   = (val_a > FRAME_MAX) || (val_b > FRAME_MAX);
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef UNARY_TX_DRAIN_EN
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LAST;
`else
          state_d = IDLE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef UNARY_TX_DRAIN_EN
      DRAIN: begin
        if (drain_cnt_q == '0) state_d = IDLE;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state and index.
    en_d         = (state_d == STREAM);
    a_bit_d      = en_d && (idx_d < a_d);
    b_bit_d      = en_d && (idx_d < b_d);
    frame_done_d = en_d && (idx_d == LAST_IDX);
`ifdef UNARY_TX_DRAIN_EN
    rw_d = (state_d == DRAIN);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sat        <= 1'b0;
      en         <= 1'b0;
      A          <= 1'b0;
      B          <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sat        <= sat_d;
      en         <= en_d;
      A          <= a_bit_d;
      B          <= b_bit_d;
      frame_done <= frame_done_d;
    end
  end

`ifdef UNARY_TX_DRAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_q   <= '0;
      read_or_write <= 1'b0;
    end else begin
      drain_cnt_q   <= drain_cnt_d;
      read_or_write <= rw_d;
    end
  end
`endif

endmodule

// File: tb/tb_unary_stream_tx.sv
// Scoreboard bench for unary_stream_tx: a cycle-level reference model queues expected
// frame bits on every accept; a negedge monitor pops and compares them against the DUT.
module tb_unary_stream_tx;

  localparam int FL = 15;
`ifdef UNARY_TX_DRAIN_EN
  localparam int DL = 16;
`else
  localparam int DL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [4:0] val_a = '0;
  logic [4:0] val_b = '0;
  logic       A, B, en, read_or_write, frame_done, sat;

  unary_stream_tx #(.FRAME_LEN(FL), .VAL_W(5), .DRAIN_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .val_a(val_a), .val_b(val_b), .A(A), .B(B), .en(en),
    .read_or_write(read_or_write), .frame_done(frame_done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit a;
    bit b;
    bit fd;
    bit s;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy = 0;
  int   acc_cnt = 0;
  bit   sat_m = 1'b0;
  bit   mon_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is FL cycles of bits plus DL drain cycles, then idle.
  always @(posedge clk) begin
    int ac, bc;
    bit s;
    cyc++;
    if (rst_n) begin
      if (busy == 0 && load_valid) begin
        ac = (int'(val_a) > FL) ? FL : int'(val_a);
        bc = (int'(val_b) > FL) ? FL : int'(val_b);
        s  = (int'(val_a) > FL) || (int'(val_b) > FL);
        sat_m = s;
        for (int k = 0; k < FL; k++)
          q.push_back('{cyc + k, (k < ac), (k < bc), (k == FL - 1), s});
        busy = FL + DL;
        acc_cnt++;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_on) begin
      chk("load_ready", load_ready, (busy == 0));
      chk("read_or_write", read_or_write, (busy >= 1 && busy <= DL));
      if (en) begin
        if (q.size() == 0) begin
          chk("spurious_en", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bit_cycle", cyc, e.cyc);
          chk("A", A, e.a);
          chk("B", B, e.b);
          chk("frame_done", frame_done, e.fd);
          chk("sat_frame", sat, e.s);
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("missing_en", 0, 1);
          void'(q.pop_front());
        end
        chk("idle_abfd", {A, B, frame_done}, 0);
        chk("sat_hold", sat, sat_m);
      end
    end
  end

  task automatic wait_acc(input int start);
    int n = 0;
    while (acc_cnt == start && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input int va, input int vb);
    int start;
    @(negedge clk);
    start = acc_cnt;
    load_valid = 1'b1;
    val_a = 5'(va);
    val_b = 5'(vb);
    wait_acc(start);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_rw"}, read_or_write, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_ready"}, load_ready, 1);
  endtask

  initial begin
    int start;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_on = 1'b1;
    idle(2);

    send(3, 5);
    idle(FL + DL + 3);
    send(0, 15);
    idle(FL + DL + 3);
    send(20, 31);
    idle(FL + DL + 3);
    send(1, 2);
    idle(FL + DL + 3);

    // Continuous load_valid: operands changed mid-frame must be ignored until idle.
    @(negedge clk);
    start = acc_cnt;
    load_valid = 1'b1;
    val_a = 5'd2;
    val_b = 5'd4;
    wait_acc(start);
    @(negedge clk);
    start = acc_cnt;
    val_a = 5'd6;
    val_b = 5'd1;
    wait_acc(start);
    @(negedge clk);
    load_valid = 1'b0;
    idle(FL + DL + 3);

    // Reset asserted during frame bit 7.
    send(9, 30);
    idle(7);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    q.delete();
    busy = 0;
    sat_m = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", load_ready, 1);
    send(7, 7);
    idle(FL + DL + 3);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) == 0);
      val_a = 5'($urandom_range(0, 31));
      val_b = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    load_valid = 1'b0;
    idle(FL + DL + 4);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
